pong_ball_engine: RTL
=====================

// Module: pong_ball_engine
// PURPOSE
// Parametrised ball engine for the Pong datapath; sits between paddle controllers and the
// VGA renderer / scoreboard. Owns ball centre position, per-axis direction and a speed that
// ramps on each paddle return. Runs a serve/play/score FSM on an internal motion tick.
// Emits one-cycle event pulses for the sound and score blocks.
// PARAMETERS
// H_RES        640     playfield width, pixels; X_W = $clog2(H_RES)
// V_RES        480     playfield height, pixels; Y_W = $clog2(V_RES)
// BALL_R       4       ball half-size; ball spans centre +/- BALL_R
// PADDLE_H     64      paddle height, pixels
// PADDLE_W     8       paddle width, pixels
// PADDLE_OFS   16      x gap between screen edge and paddle outer face
// SPEED_INIT   1       pixels per tick per axis at serve
// SPEED_MAX    8       saturation speed; SPEED_W = $clog2(SPEED_MAX+1)
// TICK_DIV     833333  clk cycles per motion tick (60 Hz at 50 MHz); must be >= 1
// SERVE_TICKS  60      ticks ball waits at centre before launch
// PORTS
// clk            in   1        master 50 MHz clock
// reset          in   1        synchronous, active-low reset
// game_on        in   1        1 = run; 0 = pause (all state and tick counter hold)
// paddle_y1      in   Y_W      left paddle top edge (player 1)
// paddle_y2      in   Y_W      right paddle top edge (player 2)
// ball_x         out  X_W      ball centre x
// ball_y         out  Y_W      ball centre y
// wall_hit       out  1        1-cycle pulse: top/bottom wall bounce
// paddle_hit     out  1        1-cycle pulse: paddle return
// player1_point  out  1        1-cycle pulse: ball passed right edge
// player2_point  out  1        1-cycle pulse: ball passed left edge
// serving        out  1        1 while FSM in IDLE or SERVE
// BEHAVIOUR
// - Reset (reset==0 at posedge clk): ball_x=H_RES/2, ball_y=V_RES/2, dir_x=+, dir_y=+,
//   speed=SPEED_INIT, tick counter=0, serve counter=0, all pulses 0, serving=1, state IDLE.
// - Reset asserted mid-operation wins over every other update in that cycle.
// - Tick: counter counts 0..TICK_DIV-1 while game_on=1; tick asserted in the wrap cycle.
// - FSM: IDLE -> SERVE on first cycle game_on=1. SERVE: on each tick serve counter++;
//   at SERVE_TICKS -> PLAY, counter cleared. PLAY: motion on each tick. On miss -> SCORE.
//   SCORE: next tick recentres ball, speed=SPEED_INIT, dir_x toward conceding player,
//   dir_y kept -> SERVE. game_on=0 freezes state in any FSM state (no transitions).
// - Motion (PLAY, tick): next = pos +/- speed computed in X_W+2 / Y_W+2 signed width.
// - Wall: next_y-BALL_R <= 0 -> ball_y=BALL_R, dir_y=+; next_y+BALL_R >= V_RES-1 ->
//   ball_y=V_RES-1-BALL_R, dir_y=-; wall_hit pulses.
// - Paddle 1 (dir_x=-): next_x-BALL_R <= PADDLE_OFS+PADDLE_W and next_x-BALL_R >= PADDLE_OFS
//   and paddle_y1-BALL_R <= ball_y <= paddle_y1+PADDLE_H+BALL_R -> ball_x=PADDLE_OFS+
//   PADDLE_W+BALL_R, dir_x=+, speed=min(speed+1,SPEED_MAX), paddle_hit pulses.
//   Paddle 2 mirrored at x=H_RES-1-PADDLE_OFS. Compare bounds in Y_W+2 signed width.
// - Miss: next_x-BALL_R <= 0 -> player2_point; next_x+BALL_R >= H_RES-1 -> player1_point;
//   ball_x clamped to edge, state SCORE. Miss only tested when no paddle hit this tick.
// - Simultaneous wall+paddle (corner) in one tick: both updates and both pulses same cycle.
// - Latency: pos/dir/speed/pulses registered in cycle after tick; pulses high exactly 1 clk.
// - ball_x/ball_y always within [BALL_R, RES-1-BALL_R]; no wrap-around.
// TESTING (TICK_DIV=1, SERVE_TICKS=2, defaults otherwise)
// - Reset, game_on=1 -> serving=1 for 3 cycles, then ball (321,241) next tick, speed 1.
// - Ball at y=6, dir_y=-, speed 3 -> ball_y=4, dir_y=+, wall_hit one cycle.
// - Ball x=29,y=100,dir_x=-, paddle_y1=80 -> ball_x=28, dir_x=+, paddle_hit, speed 1->2.
// - Same with paddle_y1=200 -> ball_x clamped 4, player2_point pulse, recentre, serve dir_x=-.
// - 10 paddle returns -> speed saturates at 8; game_on=0 mid-PLAY -> ball_x/ball_y hold.
// - reset low during SCORE -> next cycle all reset values, no point pulse emitted.

Source files
------------

// File: rtl/pong_ball_if.sv
// pong_ball_if: paddle/run inputs and ball position/event outputs of the Pong ball engine
interface pong_ball_if #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
);
  localparam int X_W = $clog2(H_RES);
  localparam int Y_W = $clog2(V_RES);
  logic           game_on;
  logic [Y_W-1:0] paddle_y1;
  logic [Y_W-1:0] paddle_y2;
  logic [X_W-1:0] ball_x;
  logic [Y_W-1:0] ball_y;
  logic           wall_hit;
  logic           paddle_hit;
  logic           player1_point;
  logic           player2_point;
  logic           serving;
  modport master (
    input  game_on, paddle_y1, paddle_y2,
    output ball_x, ball_y, wall_hit, paddle_hit, player1_point, player2_point, serving
  );
  modport slave (
    output game_on, paddle_y1, paddle_y2,
    input  ball_x, ball_y, wall_hit, paddle_hit, player1_point, player2_point, serving
  );
endinterface

// File: rtl/pong_ball_engine.sv
// pong_ball_engine: ball position/direction/speed with serve/play/score FSM on a motion tick
module pong_ball_engine #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_R      = 4,
  parameter int PADDLE_H    = 64,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_OFS  = 16,
  parameter int SPEED_INIT  = 1,
  parameter int SPEED_MAX   = 8,
  parameter int TICK_DIV    = 833333,
  parameter int SERVE_TICKS = 60
) (
  input  logic clk,
  input  logic reset,
  pong_ball_if.master bus
);
  localparam int X_W = $clog2(H_RES);
  localparam int Y_W = $clog2(V_RES);
  localparam int SPEED_W = $clog2(SPEED_MAX + 1);
  localparam int T_W = $clog2(TICK_DIV + 1);
  localparam int C_W = $clog2(SERVE_TICKS + 1);
  localparam int XS = X_W + 2;
  localparam int YS = Y_W + 2;
  // Edge tests are folded onto the ball centre so every compare stays in one signed width
  localparam logic signed [XS-1:0] X_LO  = XS'(BALL_R);
  localparam logic signed [XS-1:0] X_HI  = XS'(H_RES - 1 - BALL_R);
  localparam logic signed [XS-1:0] P1_LO = XS'(PADDLE_OFS + BALL_R);
  localparam logic signed [XS-1:0] P1_HI = XS'(PADDLE_OFS + PADDLE_W + BALL_R);
  localparam logic signed [XS-1:0] P2_LO = XS'(H_RES - 1 - PADDLE_OFS - PADDLE_W - BALL_R);
  localparam logic signed [XS-1:0] P2_HI = XS'(H_RES - 1 - PADDLE_OFS - BALL_R);
  localparam logic signed [YS-1:0] Y_LO  = YS'(BALL_R);
  localparam logic signed [YS-1:0] Y_HI  = YS'(V_RES - 1 - BALL_R);
  localparam logic signed [YS-1:0] PAD_R = YS'(BALL_R);
  localparam logic signed [YS-1:0] PAD_B = YS'(PADDLE_H + BALL_R);
  typedef enum logic [1:0] {IDLE, SERVE, PLAY, SCORE} state_t;
  state_t state, state_n;
  logic [T_W-1:0] tick_cnt;
  logic [C_W-1:0] serve_cnt;
  logic [SPEED_W-1:0] speed;
  logic [X_W-1:0] ball_x;
  logic [Y_W-1:0] ball_y;
  logic dir_x, dir_y, tick, serve_done;
  logic wall_hit, paddle_hit, player1_point, player2_point;
  logic signed [XS-1:0] nx;
  logic signed [YS-1:0] ny, by, p1, p2;
  logic wall_lo, wall_hi, hit1, hit2, miss_l, miss_r;
  assign tick = bus.game_on && tick_cnt == T_W'(TICK_DIV - 1);
  assign serve_done = serve_cnt == C_W'(SERVE_TICKS - 1);
  always_comb begin
    nx = dir_x ? $signed(XS'(ball_x)) + $signed(XS'(speed)) : $signed(XS'(ball_x)) - $signed(XS'(speed));
    ny = dir_y ? $signed(YS'(ball_y)) + $signed(YS'(speed)) : $signed(YS'(ball_y)) - $signed(YS'(speed));
    by = $signed(YS'(ball_y));
    p1 = $signed(YS'(bus.paddle_y1));
    p2 = $signed(YS'(bus.paddle_y2));
    wall_lo = ny <= Y_LO;
    wall_hi = ny >= Y_HI;
    hit1 = !dir_x && nx <= P1_HI && nx >= P1_LO && by >= p1 - PAD_R && by <= p1 + PAD_B;
    hit2 = dir_x && nx >= P2_LO && nx <= P2_HI && by >= p2 - PAD_R && by <= p2 + PAD_B;
    miss_l = nx <= X_LO;
    miss_r = nx >= X_HI;
  end
  always_ff @(posedge clk) state <= !reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (bus.game_on)
      case (state)
        IDLE:  state_n = SERVE;
        SERVE: state_n = tick && serve_done ? PLAY : SERVE;
        PLAY:  state_n = tick && !hit1 && !hit2 && (miss_l || miss_r) ? SCORE : PLAY;
        SCORE: state_n = tick ? SERVE : SCORE;
      endcase
  end
  always_comb bus.serving = state == IDLE || state == SERVE;
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt <= '0;
      serve_cnt <= '0;
      ball_x <= X_W'(H_RES / 2);
      ball_y <= Y_W'(V_RES / 2);
      dir_x <= 1'b1;
      dir_y <= 1'b1;
      speed <= SPEED_W'(SPEED_INIT);
      {wall_hit, paddle_hit, player1_point, player2_point} <= '0;
    end else begin
      {wall_hit, paddle_hit, player1_point, player2_point} <= '0;
      if (bus.game_on) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick && state == SERVE) serve_cnt <= serve_done ? '0 : serve_cnt + 1'b1;
      if (tick && state == PLAY) begin
        ball_y <= wall_lo ? Y_W'(BALL_R) : wall_hi ? Y_W'(V_RES - 1 - BALL_R) : ny[Y_W-1:0];
        dir_y <= wall_lo ? 1'b1 : wall_hi ? 1'b0 : dir_y;
        wall_hit <= wall_lo || wall_hi;
        paddle_hit <= hit1 || hit2;
        player2_point <= !hit1 && !hit2 && miss_l;
        player1_point <= !hit1 && !hit2 && !miss_l && miss_r;
        ball_x <= hit1 ? X_W'(PADDLE_OFS + PADDLE_W + BALL_R) :
                  hit2 ? X_W'(H_RES - 1 - PADDLE_OFS - PADDLE_W - BALL_R) :
                  miss_l ? X_W'(BALL_R) : miss_r ? X_W'(H_RES - 1 - BALL_R) : nx[X_W-1:0];
        if (hit1 || hit2) begin
          dir_x <= hit1;
          speed <= speed >= SPEED_W'(SPEED_MAX) ? speed : speed + 1'b1;
        end
      end
      // Ball parked at an edge tells which player conceded; serve toward them
      if (tick && state == SCORE) begin
        ball_x <= X_W'(H_RES / 2);
        ball_y <= Y_W'(V_RES / 2);
        speed <= SPEED_W'(SPEED_INIT);
        dir_x <= ball_x >= X_W'(H_RES / 2);
      end
    end
  end
  assign bus.ball_x = ball_x;
  assign bus.ball_y = ball_y;
  assign bus.wall_hit = wall_hit;
  assign bus.paddle_hit = paddle_hit;
  assign bus.player1_point = player1_point;
  assign bus.player2_point = player2_point;
endmodule
